// File: rtl/tt_sweep.sv
// Exhaustive truth-table sweeper for a 5-input combinational function:
// steps all 32 input vectors, captures y_in per vector and compares to a golden table.
module tt_sweep #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] expected,
    input  logic        y_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] table_out,
    output logic [5:0]  mismatch_count,
    output logic [4:0]  first_fail,
    output logic        first_fail_valid
);

    // state | meaning
    // IDLE  | waiting for start; results hold from the last sweep
    // RUN   | driving vector idx, sampling y_in after SETTLE cycles
    // DONE  | one-cycle completion pulse, pass valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] exp_q, exp_d;
    logic [31:0] tab_q, tab_d;
    logic [5:0]  mm_q, mm_d;
    logic [4:0]  ff_q, ff_d;
    logic        ffv_q, ffv_d;
    logic        pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tab_q   <= '0;
            mm_q    <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tab_q   <= tab_d;
            mm_q    <= mm_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        tab_d   = tab_q;
        mm_d    = mm_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    exp_d   = expected;
                    tab_d   = '0;
                    mm_d    = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q == SETTLE_M1) begin
                    cnt_d        = '0;
                    tab_d[idx_q] = y_in;
                    if (y_in != exp_q[idx_q]) begin
                        mm_d = mm_q + 6'd1;
                        if (!ffv_q) begin
                            ff_d  = idx_q;
                            ffv_d = 1'b1;
                        end
                    end
                    // Last vector: stop here rather than wrapping idx to 0.
                    if (idx_q == 5'd31) begin
                        state_d = DONE;
                        pass_d  = (mm_d == 6'd0);
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy             = (state_q == RUN);
        done             = (state_q == DONE);
        {a, b, c, d, e}  = (state_q == RUN) ? idx_q : 5'd0;
        pass             = pass_q;
        table_out        = tab_q;
        mismatch_count   = mm_q;
        first_fail       = ff_q;
        first_fail_valid = ffv_q;
    end

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: two instances (SETTLE=1 and SETTLE=3) sharing clock/reset,
// a selectable function under test, and a table-level reference model.
module tb_tt_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_req = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] expected = '0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] rtab = '0;

    int checks = 0;
    int errors = 0;
    int S = 1;

    always #5 clk = ~clk;

    logic a1, b1, c1, d1, e1, busy1, done1, pass1, ffv1, y1, start1;
    logic [31:0] tab1;
    logic [5:0]  mm1;
    logic [4:0]  ff1;
    logic a3, b3, c3, d3, e3, busy3, done3, pass3, ffv3, y3, start3;
    logic [31:0] tab3;
    logic [5:0]  mm3;
    logic [4:0]  ff3;

    function automatic logic fut(input logic [1:0] m, input logic [4:0] v, input logic [31:0] t);
        case (m)
            2'd0:    return v[0];
            2'd1:    return 1'b1;
            2'd2:    return &v;
            default: return t[v];
        endcase
    endfunction

    assign start1 = start_req && !sel;
    assign start3 = start_req && sel;
    assign y1 = fut(mode, {a1, b1, c1, d1, e1}, rtab);
    assign y3 = fut(mode, {a3, b3, c3, d3, e3}, rtab);

    tt_sweep #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected), .y_in(y1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .busy(busy1), .done(done1),
        .pass(pass1), .table_out(tab1), .mismatch_count(mm1),
        .first_fail(ff1), .first_fail_valid(ffv1));

    tt_sweep #(.SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .expected(expected), .y_in(y3),
        .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .busy(busy3), .done(done3),
        .pass(pass3), .table_out(tab3), .mismatch_count(mm3),
        .first_fail(ff3), .first_fail_valid(ffv3));

    wire [4:0]  vec  = sel ? {a3, b3, c3, d3, e3} : {a1, b1, c1, d1, e1};
    wire        busy = sel ? busy3 : busy1;
    wire        done = sel ? done3 : done1;
    wire        pass = sel ? pass3 : pass1;
    wire [31:0] tab  = sel ? tab3 : tab1;
    wire [5:0]  mm   = sel ? mm3 : mm1;
    wire [4:0]  ff   = sel ? ff3 : ff1;
    wire        ffv  = sel ? ffv3 : ffv1;

    // Per-cycle trace of one sweep and result snapshot at the done cycle.
    logic [4:0]  vec_tr [0:127];
    logic        done_tr[0:127];
    logic        busy_tr[0:127];
    logic [31:0] r_tab;
    logic [5:0]  r_mm;
    logic [4:0]  r_ff;
    logic        r_ffv, r_pass;

    // Reference results computed from the function table and the golden table.
    logic [31:0] m_tab;
    logic [5:0]  m_mm;
    logic [4:0]  m_ff;
    logic        m_ffv, m_pass;

    task automatic model(input logic [31:0] exp_val);
        m_mm  = 0;
        m_ffv = 0;
        m_ff  = 0;
        for (int i = 0; i < 32; i++) begin
            m_tab[i] = fut(mode, 5'(i), rtab);
            if (m_tab[i] != exp_val[i]) begin
                m_mm = m_mm + 6'd1;
                if (!m_ffv) begin
                    m_ff  = 5'(i);
                    m_ffv = 1'b1;
                end
            end
        end
        m_pass = (m_mm == 0);
    endtask

    // Start one sweep; optionally inject a second start (kind 1) or reset (kind 2) at cycle inj_at.
    task automatic run_sweep(input logic [31:0] exp_val, input int inj_at, input int inj_kind);
        @(negedge clk);
        expected  = exp_val;
        start_req = 1'b1;
        for (int j = 0; j <= 32 * S + 1; j++) begin
            @(negedge clk);
            if (j == 0) start_req = 1'b0;
            if (j == 1) expected = $urandom;
            vec_tr[j]  = vec;
            done_tr[j] = done;
            busy_tr[j] = busy;
            if (j == 32 * S) begin
                r_tab = tab; r_mm = mm; r_ff = ff; r_ffv = ffv; r_pass = pass;
            end
            if (j == inj_at + 1) begin
                start_req = 1'b0;
                rst       = 1'b0;
            end
            if (j == inj_at) begin
                if (inj_kind == 1) start_req = 1'b1;
                if (inj_kind == 2) rst = 1'b1;
            end
        end
    endtask

    task automatic check_sweep(input string name);
        int bad;
        bad = 0;
        for (int j = 0; j < 32 * S; j++)
            if (vec_tr[j] !== 5'(j / S) || busy_tr[j] !== 1'b1 || done_tr[j] !== 1'b0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s sequence: %0d bad cycles, required 0", name, bad);
        end
        checks++;
        if (done_tr[32*S] !== 1'b1 || busy_tr[32*S] !== 1'b0 || done_tr[32*S+1] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_timing: done=%b busy=%b next_done=%b, required 1 0 0",
                     name, done_tr[32*S], busy_tr[32*S], done_tr[32*S+1]);
        end
        checks++;
        if ({r_tab, r_mm, r_ff, r_ffv, r_pass} !== {m_tab, m_mm, m_ff, m_ffv, m_pass}) begin
            errors++;
            $display("FAIL %s results: table=%h mm=%0d ff=%0d ffv=%b pass=%b, required table=%h mm=%0d ff=%0d ffv=%b pass=%b",
                     name, r_tab, r_mm, r_ff, r_ffv, r_pass, m_tab, m_mm, m_ff, m_ffv, m_pass);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a1, b1, c1, d1, e1, busy1, done1, pass1, tab1, mm1, ff1, ffv1,
             a3, b3, c3, d3, e3, busy3, done3, pass3, tab3, mm3, ff3, ffv3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dut1 busy=%b table=%h mm=%0d, dut3 busy=%b table=%h, required all 0",
                     busy1, tab1, mm1, busy3, tab3);
        end
        rst = 1'b0;
        start_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: busy1=%b busy3=%b, required 0 0", busy1, busy3);
        end
    endtask

    task automatic test_identity();
        sel = 0; S = 1; mode = 2'd0;
        model(32'hAAAAAAAA);
        run_sweep(32'hAAAAAAAA, -5, 0);
        check_sweep("identity");
        repeat (3) @(negedge clk);
        checks++;
        if (tab !== 32'hAAAAAAAA || pass !== 1'b1 || vec !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: table=%h pass=%b vec=%0d busy=%b, required aaaaaaaa 1 0 0",
                     tab, pass, vec, busy);
        end
    endtask

    task automatic test_all_fail();
        sel = 0; S = 1; mode = 2'd1;
        model(32'h0);
        run_sweep(32'h0, -5, 0);
        check_sweep("all_fail");
    endtask

    task automatic test_and5();
        sel = 0; S = 1; mode = 2'd2;
        model(32'h80000000);
        run_sweep(32'h80000000, -5, 0);
        check_sweep("and5_pass");
        model(32'h0);
        run_sweep(32'h0, -5, 0);
        check_sweep("and5_fail");
    endtask

    task automatic test_random();
        logic [31:0] ex;
        sel = 0; S = 1; mode = 2'd3;
        for (int k = 0; k < 6; k++) begin
            rtab = $urandom;
            case (k % 3)
                0:       ex = rtab;
                1:       ex = rtab ^ (32'h1 << $urandom_range(31, 0)) ^ (32'h1 << $urandom_range(31, 0));
                default: ex = $urandom;
            endcase
            model(ex);
            run_sweep(ex, -5, 0);
            check_sweep("random");
        end
    endtask

    task automatic test_back_to_back();
        sel = 0; S = 1; mode = 2'd3;
        rtab = $urandom;
        model(~rtab);
        run_sweep(~rtab, -5, 0);
        check_sweep("back_to_back_a");
        model(rtab);
        run_sweep(rtab, -5, 0);
        check_sweep("back_to_back_b");
    endtask

    task automatic test_abort_start();
        sel = 0; S = 1; mode = 2'd0;
        model(32'h55555555);
        run_sweep(32'h55555555, 10, 1);
        check_sweep("abort_start");
    endtask

    task automatic test_abort_rst();
        int bad;
        sel = 0; S = 1; mode = 2'd1;
        run_sweep(32'h0, 10, 2);
        checks++;
        if (vec_tr[10] !== 5'd10 || busy_tr[11] !== 1'b0 || vec_tr[11] !== 5'd0) begin
            errors++;
            $display("FAIL abort_rst_entry: vec@10=%0d busy@11=%b vec@11=%0d, required 10 0 0",
                     vec_tr[10], busy_tr[11], vec_tr[11]);
        end
        bad = 0;
        for (int j = 0; j <= 33; j++) if (done_tr[j] !== 1'b0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_rst_done: %0d done cycles, required 0", bad);
        end
        checks++;
        if ({r_tab, r_mm, r_ff, r_ffv, r_pass} !== '0) begin
            errors++;
            $display("FAIL abort_rst_zero: table=%h mm=%0d ff=%0d ffv=%b pass=%b, required all 0",
                     r_tab, r_mm, r_ff, r_ffv, r_pass);
        end
        mode = 2'd0;
        model(32'hAAAAAAAA);
        run_sweep(32'hAAAAAAAA, -5, 0);
        check_sweep("after_abort");
    endtask

    task automatic test_settle();
        sel = 1; S = 3; mode = 2'd0;
        model(32'hAAAAAAAA);
        run_sweep(32'hAAAAAAAA, -5, 0);
        check_sweep("settle3");
        mode = 2'd3;
        rtab = $urandom;
        model(32'h0F0F00FF);
        run_sweep(32'h0F0F00FF, -5, 0);
        check_sweep("settle3_random");
        sel = 0; S = 1;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_fail();
        test_and5();
        test_random();
        test_back_to_back();
        test_abort_start();
        test_abort_rst();
        test_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter SETTLE, default 1, giving the cycles each input vector is held before y_in is sampled; the legal range is 1..15.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port start: input, 1 bit, a one-cycle request to begin a 32-vector sweep.
REQ-006 Port expected: input, 32 bits, the golden truth table; bit i is the expected y for vector i.
REQ-007 Port y_in: input, 1 bit, the output of the combinational 5-input function under test.
REQ-008 Ports a, b, c, d, e: outputs, 1 bit each, drive the function under test; a is vector index bit 4 and e is index bit 0.
REQ-009 Port busy: output, 1 bit, high while a sweep is in progress.
REQ-010 Port done: output, 1 bit, a one-cycle pulse when the sweep completes.
REQ-011 Port pass: output, 1 bit, high when the captured table equals the latched expected table.
REQ-012 Port table_out: output, 32 bits, the captured truth table; bit i is y_in sampled for vector i.
REQ-013 Port mismatch_count: output, 6 bits, the number of mismatching vectors, 0..32.
REQ-014 Port first_fail: output, 5 bits, the lowest mismatching vector index.
REQ-015 Port first_fail_valid: output, 1 bit, high when at least one mismatch has been recorded.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE: the block SHALL accept start only in IDLE; on acceptance it latches expected, clears table_out, mismatch_count, first_fail, first_fail_valid and pass, sets idx=0 and cnt=0, and enters RUN.
REQ-018 RUN: busy=1; {a,b,c,d,e} SHALL equal idx, updated on the same edge that changes idx.
REQ-019 RUN: cnt SHALL increment every cycle; at the edge where cnt==SETTLE-1 the block samples y_in into table_out[idx], sets cnt=0 and increments idx.
REQ-020 RUN compare rule: on each sample, if y_in differs from latched expected[idx], mismatch_count SHALL increment; if first_fail_valid=0, first_fail takes idx and first_fail_valid sets.
REQ-021 RUN exit: the sample of idx=31 SHALL move the FSM to DONE; idx does not wrap into a 33rd vector.
REQ-022 DONE: done=1 and busy=0 for exactly one cycle, pass=(mismatch_count==0), then the FSM returns to IDLE.
REQ-023 Latency: done SHALL be high in the cycle following the edge 32*SETTLE cycles after the edge that accepted start.
REQ-024 In IDLE, {a,b,c,d,e} SHALL be 0; table_out, mismatch_count, first_fail, first_fail_valid and pass hold their last values until the next accepted start.
REQ-025 A start asserted in RUN or DONE SHALL be ignored, with no effect on idx, results or a later sweep.
REQ-026 Changes on expected after acceptance SHALL not affect the current sweep.
REQ-027 mismatch_count SHALL saturate-free count to 32, which fits in 6 bits, with no overflow possible.

Reset
REQ-028 When rst is high at a rising edge, the FSM SHALL enter IDLE.
REQ-029 On reset, idx, cnt and the latched expected SHALL clear.
REQ-030 On reset, a..e, busy, done, pass, table_out, mismatch_count, first_fail and first_fail_valid SHALL all be 0.
REQ-031 Reset SHALL take priority over start in the same cycle.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.

Verification
REQ-033 Reset check: rst high 2 cycles -> all outputs 0, busy=0; start held with rst -> stays IDLE.
REQ-034 Identity check: SETTLE=1, y_in=e, expected=32'hAAAAAAAA, start -> a..e count 0..31 one per cycle; done 32 cycles after start; table_out=32'hAAAAAAAA, pass=1, mismatch_count=0, first_fail_valid=0.
REQ-035 All-fail check: y_in=1, expected=0 -> table_out=32'hFFFFFFFF, mismatch_count=32, first_fail=0, first_fail_valid=1, pass=0.
REQ-036 AND5 check: y_in=a&b&c&d&e, expected=32'h80000000 -> pass=1; repeat with expected=0 -> mismatch_count=1, first_fail=31, pass=0.
REQ-037 Abort check: start again at idx=10 -> ignored, sweep completes normally; separately, rst at idx=10 -> IDLE with zeroed outputs and no done; next start begins at idx 0.
REQ-038 Settle check: SETTLE=3, y_in=e -> each vector held 3 cycles, done 96 cycles after start, table_out=32'hAAAAAAAA.
